// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: dmem req/ack transaction, lane alignment, load extension, writeback
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word raises bus_err without a bus request).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] alu_result_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        req_q, we_q, wb_valid_q, wb_we_q, bus_err_q;
  logic [31:0] addr_q, wdata_q, wb_data_q;
  logic [3:0]  be_q;
  logic [4:0]  wb_rd_q;
  logic        is_load_q, byte_q, half_q, signed_q;
  logic [1:0]  lo_q;

  logic        is_byte_d, is_half_d, misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_data_d, byte_shift;
  logic [15:0] half_sel;

  // Undefined width codes fall through to a word access; 100/101 are loads-only.
  always_comb begin
    is_byte_d = (funct3_i == 3'b000) || (is_load_i && funct3_i == 3'b100);
    is_half_d = (funct3_i == 3'b001) || (is_load_i && funct3_i == 3'b101);
    be_d      = 4'b1111;
    wdata_d   = store_data_i;
    if (is_byte_d) begin
      be_d    = 4'b0001 << mem_address_i[1:0];
      wdata_d = {4{store_data_i[7:0]}};
    end else if (is_half_d) begin
      be_d    = 4'b0011 << {mem_address_i[1], 1'b0};
      wdata_d = {2{store_data_i[15:0]}};
    end
`ifdef MISALIGN_TRAP_EN
    misalign_d = (is_half_d && mem_address_i[0]) ||
                 (!is_byte_d && !is_half_d && (mem_address_i[1:0] != 2'b00));
`else
    misalign_d = 1'b0;
`endif
  end

  always_comb begin
    byte_shift  = dmem_rdata_i >> {lo_q, 3'b000};
    half_sel    = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_data_d = dmem_rdata_i;
    if (byte_q)
      load_data_d = signed_q ? {{24{byte_shift[7]}}, byte_shift[7:0]} : {24'b0, byte_shift[7:0]};
    else if (half_q)
      load_data_d = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      bus_err_q  <= 1'b0;
      is_load_q  <= 1'b0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      signed_q   <= 1'b0;
      lo_q       <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            wb_rd_q <= rd_i;
            if (is_load_i || is_store_i) begin
              if (misalign_d) begin
                wb_valid_q <= 1'b1;
                bus_err_q  <= 1'b1;
                wb_data_q  <= '0;
                state_q    <= RESP;
              end else begin
                req_q     <= 1'b1;
                we_q      <= is_store_i;
                addr_q    <= {mem_address_i[31:2], 2'b00};
                wdata_q   <= wdata_d;
                be_q      <= be_d;
                is_load_q <= is_load_i;
                byte_q    <= is_byte_d;
                half_q    <= is_half_d;
                signed_q  <= ~funct3_i[2];
                lo_q      <= mem_address_i[1:0];
                cnt_q     <= '0;
                state_q   <= ACCESS;
              end
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= (rd_i != 5'd0);
              wb_data_q  <= alu_result_i;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= is_load_q && (wb_rd_q != 5'd0);
            wb_data_q  <= is_load_q ? load_data_d : 32'd0;
            cnt_q      <= '0;
            state_q    <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            bus_err_q  <= 1'b1;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_we_o      = wb_we_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign bus_err_o    = bus_err_q;

endmodule
